// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-word transmit FIFO feeding a 5..9 bit UART serialiser
// with optional even/odd parity and one or two stop bits.
// Latency: a word pushed at edge E starts on the first baud tick strictly after E.
// Backpressure: in_ready drops while the FIFO is full or rst is high; a pop in
// the same cycle does not free a slot early.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   baud_en_tx       one-cycle pulse per bit period from the baud generator
//   in_valid/in_data push interface; in_ready is the combinational accept
//   parity_mode      00/11 none, 01 even, 10 odd (latched at frame load)
//   two_stop         0 one stop bit, 1 two stop bits (latched at frame load)
//   tx_data_out      registered serial line, idle high
//   tx_active        high from the start-bit edge until the last stop bit ends
//   tx_done          one-cycle pulse after the final stop-bit tick
//   fifo_count       number of words currently held
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_en_tx,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  output logic                     tx_data_out,
  output logic                     tx_active,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Serialiser state
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IW-1:0]    r_bit_idx;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_two_stop;
  logic             r_stop2;
  logic             r_tx;
  logic             r_active;
  logic             r_done;

  logic             w_push;
  logic             w_pop;
  logic             w_frame_end;
  logic             w_not_empty;
  logic [WIDTH-1:0] w_head;
  logic             w_head_par;
  logic             w_par_en;

  assign in_ready    = !rst && (r_count != FULL_CNT);
  assign w_push      = in_valid && in_ready;
  assign w_not_empty = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  // The frame ends on the stop tick unless a second stop bit is still owed.
  assign w_frame_end = baud_en_tx && (r_state == S_STOP) && !(r_two_stop && !r_stop2);

  // A pop only ever happens on a frame-start edge: from IDLE or straight out
  // of the last stop bit for back-to-back frames.
  assign w_pop = baud_en_tx && w_not_empty &&
                 ((r_state == S_IDLE) || w_frame_end);

  assign w_par_en   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign w_head_par = (^w_head) ^ (parity_mode == 2'b10);

  // Storage is not reset; w_push is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (baud_en_tx) begin
        case (r_state)
          S_IDLE: begin
            r_tx     <= 1'b1;
            r_active <= 1'b0;
          end
          S_START: begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
          S_DATA: begin
            if (r_bit_idx != LAST_IDX) begin
              r_bit_idx <= r_bit_idx + IW'(1);
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end else if (r_par_en) begin
              r_state <= S_PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state <= S_STOP;
              r_stop2 <= 1'b0;
              r_tx    <= 1'b1;
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_stop2 <= 1'b0;
            r_tx    <= 1'b1;
          end
          S_STOP: begin
            if (r_two_stop && !r_stop2) begin
              r_stop2 <= 1'b1;
            end else begin
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
              r_active <= 1'b0;
              r_tx     <= 1'b1;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_active <= 1'b0;
          end
        endcase

        // Frame load overrides the IDLE / end-of-frame defaults above, so a
        // queued word follows the last stop bit with no idle tick.
        if (w_pop) begin
          r_state    <= S_START;
          r_tx       <= 1'b0;
          r_active   <= 1'b1;
          r_shift    <= w_head;
          r_par_en   <= w_par_en;
          r_par_bit  <= w_head_par;
          r_two_stop <= two_stop;
          r_stop2    <= 1'b0;
        end
      end
    end
  end

  assign tx_data_out = r_tx;
  assign tx_active   = r_active;
  assign tx_done     = r_done;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  typedef struct {
    logic [7:0] d;
    logic       par_en;
    logic       par_bit;
    logic       two;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       baud_en_tx;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_data_out;
  logic       tx_active;
  logic       tx_done;
  logic [2:0] fifo_count;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   frames_done = 0;
  int   done_cnt = 0;
  int   active_drops = 0;
  int   active_cnt = 0;
  bit   mon_en = 1'b1;
  bit   chk_active = 1'b0;
  bit   tick_on = 1'b0;
  bit   man_tick = 1'b0;
  bit   tick_seen = 1'b0;
  int   tick_cnt = 0;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_en_tx  (baud_en_tx),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx_data_out (tx_data_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud ticks every 16 cycles when enabled, otherwise a manual pulse.
  initial begin
    baud_en_tx = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (tick_on) begin
        baud_en_tx = (tick_cnt == 15);
        tick_cnt   = (tick_cnt + 1) % 16;
      end else begin
        baud_en_tx = man_tick;
      end
    end
  end

  always @(posedge clk) tick_seen <= baud_en_tx;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_active) active_cnt++;
    if (chk_active && !tx_active) active_drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_tick();
    @(negedge clk);
    while (!tick_seen) @(negedge clk);
  endtask

  // Frame monitor: decodes each frame on tick boundaries and compares it
  // against the head of the scoreboard.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      wait_tick();
      if (mon_en && tx_data_out == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) begin
            wait_tick();
            got[i] = tx_data_out;
          end
          check("frame_data", got, e.d);
          if (e.par_en) begin
            wait_tick();
            check("parity_bit", tx_data_out, e.par_bit);
          end
          wait_tick();
          check("stop1", tx_data_out, 1);
          if (e.two) begin
            wait_tick();
            check("stop2", tx_data_out, 1);
          end
          frames_done++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    acc = in_ready;
    if (acc) begin
      e.d       = d;
      e.par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      e.par_bit = (^d) ^ (parity_mode == 2'b10);
      e.two     = two_stop;
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic push1(input logic [7:0] d);
    bit acc;
    push(d, acc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frames_seen", frames_done, target);
  endtask

  task automatic wait_active(input int budget);
    int k = 0;
    @(negedge clk);
    while (!tx_active && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("active_rise", tx_active, 1);
  endtask

  task automatic stall();
    tick_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   d0;
    int   acc_n;
    bit   acc;
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    parity_mode = 2'b00;
    two_stop = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", tx_data_out, 1);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);
    tick_on = 1'b1;

    // Basic frame 0xA5, no parity, one stop
    d0 = done_cnt;
    push1(8'hA5);
    wait_frames(1, 300);
    repeat (40) @(negedge clk);
    check("basic_done_pulses", done_cnt - d0, 1);
    check("basic_active_fall", tx_active, 0);

    // Parity variants
    parity_mode = 2'b01;
    push1(8'hA5);
    wait_frames(2, 300);
    repeat (40) @(negedge clk);
    parity_mode = 2'b10;
    push1(8'hA5);
    wait_frames(3, 300);
    repeat (40) @(negedge clk);
    two_stop = 1'b1;
    push1(8'hFF);
    wait_frames(4, 300);
    repeat (40) @(negedge clk);
    check("two_stop_idle", tx_active, 0);
    parity_mode = 2'b00;
    two_stop = 1'b0;

    // Back-to-back frames
    d0 = done_cnt;
    active_drops = 0;
    push(8'h01, acc);
    push(8'h80, acc);
    push(8'h3C, acc);
    @(negedge clk);
    in_valid = 1'b0;
    wait_active(40);
    chk_active = 1'b1;
    wait_frames(7, 1000);
    chk_active = 1'b0;
    repeat (40) @(negedge clk);
    check("b2b_no_gap", active_drops, 0);
    check("b2b_done_pulses", done_cnt - d0, 3);

    // Overflow with TX stalled
    stall();
    acc_n = 0;
    for (int i = 1; i <= 5; i++) begin
      push(8'(i * 8'h11), acc);
      if (acc) acc_n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_accepts", acc_n, 4);
    check("ovf_count", fifo_count, 4);
    check("ovf_ready", in_ready, 0);
    tick_on = 1'b1;
    wait_active(40);
    check("ovf_ready_after_pop", in_ready, 1);
    check("ovf_count_after_pop", fifo_count, 3);
    wait_frames(11, 1400);
    repeat (40) @(negedge clk);
    check("ovf_drained", fifo_count, 0);

    // Push coinciding with a frame-start pop at count 2
    stall();
    push(8'h5A, acc);
    push(8'hC3, acc);
    @(negedge clk);
    in_valid = 1'b0;
    check("pp_count_before", fifo_count, 2);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h0F;
    man_tick = 1'b1;
    #1;
    if (in_ready) begin
      e.d = 8'h0F; e.par_en = 1'b0; e.par_bit = 1'b0; e.two = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    man_tick = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_count_same", fifo_count, 2);
    check("pp_started", tx_active, 1);
    tick_on = 1'b1;
    wait_frames(14, 1000);
    repeat (40) @(negedge clk);

    // Reset during DATA bit 3 with two words queued
    mon_en = 1'b0;
    stall();
    push(8'h96, acc);
    push(8'h69, acc);
    push(8'hF0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.delete();
    tick_on = 1'b1;
    wait_active(40);
    for (int k = 0; k < 4; k++) wait_tick();
    check("mid_count", fifo_count, 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_line", tx_data_out, 1);
    check("mid_rst_active", tx_active, 0);
    check("mid_rst_count", fifo_count, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    active_cnt = 0;
    repeat (16 * 30) @(negedge clk);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_frames", active_cnt, 0);
    check("mid_line_idle", tx_data_out, 1);
    check("mid_count_after", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
